mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_pkg.sv | 7 +
 rtl/mul_arbiter_if.sv | 23 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/mul_arbiter.sv | 94 +++++++++
 tb/tb_mul_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared multiplier widths, arbiter FSM states and defaults
package mul_pkg;
  localparam int WIDTH = 16;
  localparam bit FpuMultiplier = 1'b0;
  localparam int ARB_TIMEOUT_DEFAULT = 64;
  typedef enum logic [2:0] {IDLE, ISSUE, RUN, CAPTURE, RESP} arb_state_t;
endpackage

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: requester-side request/response bundle of the multiplier arbiter
interface mul_arbiter_if #(
  parameter int NREQ = 2
);
  import mul_pkg::*;
  logic [NREQ-1:0] req_valid_i;
  logic [NREQ-1:0] req_ready_o;
  logic signed [WIDTH-1:0] req_a_i [NREQ];
  logic signed [WIDTH-1:0] req_b_i [NREQ];
  logic [NREQ-1:0] rsp_valid_o;
  logic [NREQ-1:0] rsp_ready_i;
  logic signed [2*WIDTH-1:0] rsp_product_o;
  logic signed [WIDTH-1:0] rsp_rounded_o;
  logic rsp_err_o;
  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_product_o, rsp_rounded_o, rsp_err_o
  );
  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_product_o, rsp_rounded_o, rsp_err_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or above ptr, with wrap-around
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);
  localparam logic [IDW:0] NR = (IDW+1)'(NREQ);
  logic [NREQ-1:0] rot;
  logic [IDW-1:0] off;
  logic [IDW:0] sum;
  assign rot = NREQ'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int i = NREQ-1; i >= 0; i--) if (rot[i]) off = IDW'(i);
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign any = |req;
  assign gnt_id = sum >= NR ? IDW'(sum - NR) : sum[IDW-1:0];
  assign gnt = any ? NREQ'(1) << gnt_id : '0;
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one external multiplier datapath among NREQ requesters with a watchdog
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mul_arbiter_if.slave              bus,
  output logic                      mul_start_o,
  output logic signed [WIDTH-1:0]   mul_multiplicand_o,
  output logic signed [WIDTH-1:0]   mul_multiplier_o,
  input  logic signed [2*WIDTH-1:0] mul_product_i,
  input  logic signed [WIDTH-1:0]   mul_product_rounded_i,
  input  logic                      mul_done_i,
  output logic                      busy_o
);
  localparam int IDW = NREQ > 2 ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  arb_state_t state;
  logic [IDW-1:0] rr_ptr, owner, gnt_id;
  logic [NREQ-1:0] gnt, rsp_valid;
  logic any;
  logic [WDW-1:0] wd;
  logic signed [WIDTH-1:0] op_a, op_b, rnd;
  logic signed [2*WIDTH-1:0] prod;
  logic err;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req(bus.req_valid_i), .ptr(rr_ptr), .gnt(gnt), .gnt_id(gnt_id), .any(any)
  );
  // grant is visible only in IDLE and is forced low while reset is held
  assign bus.req_ready_o = (state == IDLE && rst_n) ? gnt : '0;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_product_o = prod;
  assign bus.rsp_rounded_o = rnd;
  assign bus.rsp_err_o = err;
  assign mul_multiplicand_o = op_a;
  assign mul_multiplier_o = op_b;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      op_a <= '0;
      op_b <= '0;
      wd <= '0;
      mul_start_o <= 1'b0;
      rsp_valid <= '0;
      prod <= '0;
      rnd <= '0;
      err <= 1'b0;
    end else begin
      mul_start_o <= 1'b0;
      case (state)
        IDLE: if (any) begin
          op_a <= bus.req_a_i[gnt_id];
          op_b <= bus.req_b_i[gnt_id];
          owner <= gnt_id;
          mul_start_o <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          wd <= '0;
          state <= RUN;
        end
        // RUN begins the cycle after start, so TIMEOUT-2 here lands the response TIMEOUT cycles after start
        RUN: if (mul_done_i) state <= CAPTURE;
        else if (wd == WDW'(TIMEOUT - 2)) begin
          prod <= '0;
          rnd <= '0;
          err <= 1'b1;
          rsp_valid <= NREQ'(1) << owner;
          state <= RESP;
        end else wd <= wd + 1'b1;
        CAPTURE: begin
          prod <= FpuMultiplier ? '0 : mul_product_i;
          rnd <= FpuMultiplier ? mul_product_rounded_i : '0;
          err <= 1'b0;
          rsp_valid <= NREQ'(1) << owner;
          state <= RESP;
        end
        RESP: if (bus.rsp_ready_i[owner]) begin
          rsp_valid <= '0;
          err <= 1'b0;
          rr_ptr <= owner == IDW'(NREQ - 1) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized self-checking bench against a round-robin/product reference model
module tb_mul_arbiter;
  import mul_pkg::*;
  localparam int N = 2;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mul_arbiter_if #(.NREQ(N)) bus();
  logic mul_start_o, busy_o;
  logic signed [WIDTH-1:0] mul_multiplicand_o, mul_multiplier_o;
  logic signed [2*WIDTH-1:0] mul_product_i = '0;
  logic signed [WIDTH-1:0] mul_product_rounded_i = '0;
  logic mul_done_i = 1'b0;
  mul_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mul_start_o(mul_start_o), .mul_multiplicand_o(mul_multiplicand_o),
    .mul_multiplier_o(mul_multiplier_o), .mul_product_i(mul_product_i),
    .mul_product_rounded_i(mul_product_rounded_i), .mul_done_i(mul_done_i),
    .busy_o(busy_o)
  );
  int vectors = 0;
  int miscompares = 0;
  int lat_cfg = 9;
  bit dp_off = 1'b0;
  int dp_cnt = 0;
  int m_ptr = 0;
  // datapath stand-in: done pulses lat_cfg cycles after start, product held until next start
  always @(negedge clk) begin
    mul_done_i = 1'b0;
    if (!rst_n) dp_cnt = 0;
    else begin
      if (dp_cnt > 0) begin
        dp_cnt--;
        mul_done_i = (dp_cnt == 0);
      end
      if (mul_start_o && !dp_off) begin
        dp_cnt = lat_cfg;
        mul_product_i = mul_multiplicand_o * mul_multiplier_o;
        mul_product_rounded_i = mul_product_i[2*WIDTH-2:WIDTH-1] ^ 16'h00ff;
      end
    end
  end
  function automatic logic signed [2*WIDTH-1:0] ref_mul(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
    return (2*WIDTH)'(longint'(a) * longint'(b));
  endfunction
  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input int r, input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
    bus.req_valid_i[r] = 1'b1;
    bus.req_a_i[r] = a;
    bus.req_b_i[r] = b;
    step();
    bus.req_valid_i[r] = 1'b0;
  endtask
  task automatic wait_rsp(input int start_lat, output int lat);
    lat = start_lat;
    while (bus.rsp_valid_o == '0 && lat < 400) begin
      step();
      lat++;
    end
  endtask
  task automatic ack(input int r);
    bus.rsp_ready_i[r] = 1'b1;
    step();
    bus.rsp_ready_i[r] = 1'b0;
    m_ptr = (r + 1) % N;
  endtask
  task automatic test_reset();
    bus.req_valid_i = '1;
    step();
    step();
    vectors++;
    if (bus.req_ready_o !== '0) begin miscompares++; $display("FAIL reset_ready got %b exp 00", bus.req_ready_o); end
    vectors++;
    if ({bus.rsp_valid_o, busy_o, mul_start_o, bus.rsp_err_o} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl got %b exp 00000", {bus.rsp_valid_o, busy_o, mul_start_o, bus.rsp_err_o});
    end
    vectors++;
    if ({mul_multiplicand_o, mul_multiplier_o, bus.rsp_product_o} !== '0) begin
      miscompares++; $display("FAIL reset_data got %h exp 0", {mul_multiplicand_o, mul_multiplier_o, bus.rsp_product_o});
    end
    bus.req_valid_i = '0;
    rst_n = 1'b1;
    m_ptr = 0;
    step();
  endtask
  task automatic test_single();
    int lat;
    lat_cfg = 9;
    bus.req_valid_i[0] = 1'b1;
    bus.req_a_i[0] = -16'sd3;
    bus.req_b_i[0] = 16'sd7;
    #1;
    vectors++;
    if (bus.req_ready_o !== 2'b01) begin miscompares++; $display("FAIL single_ready got %b exp 01", bus.req_ready_o); end
    step();
    bus.req_valid_i[0] = 1'b0;
    vectors++;
    if ({mul_start_o, busy_o} !== 2'b11 || mul_multiplicand_o !== -16'sd3 || mul_multiplier_o !== 16'sd7) begin
      miscompares++; $display("FAIL single_start got start=%b a=%0d b=%0d exp 1 -3 7", mul_start_o, mul_multiplicand_o, mul_multiplier_o);
    end
    step();
    vectors++;
    if (mul_start_o !== 1'b0) begin miscompares++; $display("FAIL single_start_pulse got %b exp 0", mul_start_o); end
    wait_rsp(2, lat);
    vectors++;
    if (lat != 12) begin miscompares++; $display("FAIL single_latency got %0d exp 12", lat); end
    vectors++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_product_o !== -32'sd21 || bus.rsp_err_o !== 1'b0 || bus.rsp_rounded_o !== '0) begin
      miscompares++; $display("FAIL single_rsp got v=%b p=%0d e=%b r=%0d exp 01 -21 0 0", bus.rsp_valid_o, bus.rsp_product_o, bus.rsp_err_o, bus.rsp_rounded_o);
    end
    ack(0);
    vectors++;
    if ({bus.rsp_valid_o, busy_o} !== 3'b000) begin miscompares++; $display("FAIL single_done got %b exp 000", {bus.rsp_valid_o, busy_o}); end
  endtask
  task automatic test_random();
    int lat, r, bp;
    logic signed [WIDTH-1:0] a, b;
    logic signed [2*WIDTH-1:0] e;
    for (int it = 0; it < 20; it++) begin
      r = int'($urandom_range(0, N - 1));
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      e = ref_mul(a, b);
      lat_cfg = int'($urandom_range(1, 20));
      issue(r, a, b);
      wait_rsp(1, lat);
      vectors++;
      if (lat != 3 + lat_cfg) begin miscompares++; $display("FAIL rand_latency it=%0d got %0d exp %0d", it, lat, 3 + lat_cfg); end
      vectors++;
      if (bus.rsp_valid_o !== N'(1) << r || bus.rsp_product_o !== e || {bus.rsp_err_o, bus.rsp_rounded_o} !== '0) begin
        miscompares++; $display("FAIL rand_rsp it=%0d got v=%b p=%0d exp v=%b p=%0d", it, bus.rsp_valid_o, bus.rsp_product_o, N'(1) << r, e);
      end
      bp = int'($urandom_range(0, 3));
      repeat (bp) step();
      vectors++;
      if (bus.rsp_product_o !== e) begin miscompares++; $display("FAIL rand_hold it=%0d got %0d exp %0d", it, bus.rsp_product_o, e); end
      ack(r);
    end
  endtask
  task automatic test_contention();
    int lat, e, g, prev;
    logic signed [WIDTH-1:0] a [N];
    logic signed [WIDTH-1:0] b [N];
    prev = -1;
    lat_cfg = 3;
    for (int k = 0; k < N; k++) begin
      a[k] = WIDTH'($urandom);
      b[k] = WIDTH'($urandom);
      bus.req_a_i[k] = a[k];
      bus.req_b_i[k] = b[k];
    end
    bus.req_valid_i = '1;
    #1;
    for (int it = 0; it < 4; it++) begin
      e = exp_grant('1);
      g = bus.req_ready_o[1] ? 1 : 0;
      vectors++;
      if (bus.req_ready_o !== N'(1) << e) begin miscompares++; $display("FAIL cont_grant it=%0d got %b exp %b", it, bus.req_ready_o, N'(1) << e); end
      vectors++;
      if (g == prev) begin miscompares++; $display("FAIL cont_repeat it=%0d got %0d exp not %0d", it, g, prev); end
      step();
      vectors++;
      if (bus.req_ready_o !== '0) begin miscompares++; $display("FAIL cont_busy_ready it=%0d got %b exp 00", it, bus.req_ready_o); end
      wait_rsp(1, lat);
      vectors++;
      if (bus.rsp_product_o !== ref_mul(a[e], b[e]) || bus.rsp_valid_o !== N'(1) << e) begin
        miscompares++; $display("FAIL cont_rsp it=%0d got %0d exp %0d", it, bus.rsp_product_o, ref_mul(a[e], b[e]));
      end
      ack(e);
      prev = g;
    end
    bus.req_valid_i = '0;
  endtask
  task automatic test_backpressure();
    int lat;
    logic signed [WIDTH-1:0] a, b;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom) | 16'sd1;
    lat_cfg = 5;
    issue(0, a, b);
    wait_rsp(1, lat);
    bus.req_valid_i[1] = 1'b1;
    bus.rsp_ready_i[1] = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (bus.rsp_valid_o !== 2'b01 || bus.rsp_product_o !== ref_mul(a, b) || busy_o !== 1'b1 || bus.req_ready_o !== '0) begin
        miscompares++; $display("FAIL bp_hold c=%0d got v=%b p=%0d busy=%b rdy=%b exp 01 %0d 1 00", c, bus.rsp_valid_o, bus.rsp_product_o, busy_o, bus.req_ready_o, ref_mul(a, b));
      end
      step();
    end
    bus.req_valid_i[1] = 1'b0;
    bus.rsp_ready_i[1] = 1'b0;
    ack(0);
    vectors++;
    if ({bus.rsp_valid_o, busy_o} !== 3'b000) begin miscompares++; $display("FAIL bp_release got %b exp 000", {bus.rsp_valid_o, busy_o}); end
  endtask
  task automatic test_timeout();
    int lat;
    logic signed [WIDTH-1:0] a, b;
    dp_off = 1'b1;
    issue(1, 16'sd100, 16'sd100);
    wait_rsp(1, lat);
    vectors++;
    if (lat != TO + 1) begin miscompares++; $display("FAIL to_latency got %0d exp %0d", lat, TO + 1); end
    vectors++;
    if (bus.rsp_valid_o !== 2'b10 || bus.rsp_err_o !== 1'b1 || bus.rsp_product_o !== '0) begin
      miscompares++; $display("FAIL to_rsp got v=%b e=%b p=%0d exp 10 1 0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_product_o);
    end
    ack(1);
    dp_off = 1'b0;
    lat_cfg = 4;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    issue(0, a, b);
    wait_rsp(1, lat);
    vectors++;
    if (lat != 7 || bus.rsp_err_o !== 1'b0 || bus.rsp_product_o !== ref_mul(a, b)) begin
      miscompares++; $display("FAIL to_recover got lat=%0d e=%b p=%0d exp 7 0 %0d", lat, bus.rsp_err_o, bus.rsp_product_o, ref_mul(a, b));
    end
    ack(0);
  endtask
  task automatic test_reset_mid();
    int lat, seen;
    logic signed [WIDTH-1:0] a, b;
    lat_cfg = 9;
    issue(1, 16'sd5, 16'sd9);
    repeat (4) step();
    bus.req_valid_i = '1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.rsp_valid_o, busy_o, mul_start_o, bus.req_ready_o} !== 6'b0 || mul_multiplicand_o !== '0) begin
      miscompares++; $display("FAIL rmid_outputs got %b a=%0d exp 000000 0", {bus.rsp_valid_o, busy_o, mul_start_o, bus.req_ready_o}, mul_multiplicand_o);
    end
    bus.req_valid_i = '0;
    step();
    step();
    rst_n = 1'b1;
    m_ptr = 0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.rsp_valid_o != '0 || busy_o) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL rmid_stale got %0d exp 0", seen); end
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    for (int k = 0; k < N; k++) begin
      bus.req_a_i[k] = a;
      bus.req_b_i[k] = b;
    end
    bus.req_valid_i = '1;
    #1;
    vectors++;
    if (bus.req_ready_o !== N'(1) << exp_grant('1)) begin miscompares++; $display("FAIL rmid_grant got %b exp 01", bus.req_ready_o); end
    step();
    bus.req_valid_i = '0;
    wait_rsp(1, lat);
    vectors++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_product_o !== ref_mul(a, b)) begin
      miscompares++; $display("FAIL rmid_rsp got v=%b p=%0d exp 01 %0d", bus.rsp_valid_o, bus.rsp_product_o, ref_mul(a, b));
    end
    ack(0);
  endtask
  task automatic test_corner();
    int lat;
    logic signed [WIDTH-1:0] r;
    lat_cfg = 2;
    issue(0, -16'sd32768, -16'sd32768);
    wait_rsp(1, lat);
    vectors++;
    if (bus.rsp_product_o !== 32'sh4000_0000) begin miscompares++; $display("FAIL corner_min got %h exp 40000000", bus.rsp_product_o); end
    ack(0);
    r = WIDTH'($urandom) | 16'sd1;
    issue(1, 16'sd0, r);
    wait_rsp(1, lat);
    vectors++;
    if (bus.rsp_product_o !== '0 || bus.rsp_valid_o !== 2'b10) begin
      miscompares++; $display("FAIL corner_zero_a got v=%b p=%0d exp 10 0", bus.rsp_valid_o, bus.rsp_product_o);
    end
    ack(1);
    issue(0, r, 16'sd0);
    wait_rsp(1, lat);
    vectors++;
    if (bus.rsp_product_o !== '0) begin miscompares++; $display("FAIL corner_zero_b got %0d exp 0", bus.rsp_product_o); end
    ack(0);
  endtask
  initial begin
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    for (int k = 0; k < N; k++) begin
      bus.req_a_i[k] = '0;
      bus.req_b_i[k] = '0;
    end
    test_reset();
    test_single();
    test_random();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
